display_frame_streamer: RTL
===========================

Name: display_frame_streamer

Overview:
- Downstream consumer of the 512-bit `display` bus (64 pixels x 8 bits) produced by the app/display-logic stage.
- On each display change it snapshots the whole frame and serialises it as a byte stream to the UART TX stage over a valid/ready handshake.
- Frame format: sync byte, then 64 pixel bytes (pixel 0 first), then an XOR checksum byte.
- Changes that arrive mid-frame are coalesced into one follow-up frame and never interrupt the frame in flight.

Parameters:
- PIXEL_COUNT, 64, number of pixels per frame.
- PIXEL_WIDTH, 8, bits per pixel (one UART byte).
- SYNC_BYTE, 8'hFF, frame header value. Legal pixels use bits [5:0] only, so 8'hFF never collides with pixel data.

Ports:
- CLK  in  1  system clock; all logic on posedge.
- RST  in  1  synchronous, active-high reset.
- display  in  PIXEL_COUNT*PIXEL_WIDTH  frame contents; pixel i = display[i*8 +: 8].
- display_changed  in  1  one-cycle pulse: frame content changed, send it.
- force_refresh  in  1  one-cycle pulse: resend the current frame; treated identically to display_changed.
- tx_ready  in  1  UART TX can accept a byte this cycle.
- tx_valid  out  1  tx_data holds a valid byte.
- tx_data  out  8  byte to transmit.
- busy  out  1  high in any non-IDLE state.
- overrun_count  out  8  saturating count of change requests coalesced away.

Behaviour:
- Reset values: state IDLE; tx_valid=0; tx_data=0; busy=0; pending=0; overrun_count=0; snapshot=0; checksum=0; pixel index=0.
- Reset mid-frame aborts the frame immediately: no further bytes, and pending is cleared.
- Request: req = display_changed | force_refresh.
- Handshake:
  - A byte transfers on a cycle where tx_valid & tx_ready.
  - While tx_valid=1 and tx_ready=0, tx_data and tx_valid hold stable.
  - The next byte is presented the cycle after a transfer, so back-to-back transfers run at 1 byte/cycle when tx_ready stays high.
- States:
  - IDLE: on req, capture display into the snapshot register, clear checksum and pixel index, go to HEADER. Latency: tx_valid=1 with tx_data=SYNC_BYTE on the next cycle.
  - HEADER: present SYNC_BYTE. On transfer, go to PIXELS with index=0.
  - PIXELS: present snapshot byte[index]. On transfer: checksum ^= byte; if index==PIXEL_COUNT-1 go to CHECKSUM, else index+1.
  - CHECKSUM: present the accumulated XOR of all 64 pixel bytes (SYNC excluded). On transfer:
    - If pending | req: recapture display, clear pending, go to HEADER. tx_valid stays high; the next frame's SYNC follows on the next cycle.
    - Otherwise go to IDLE with tx_valid=0.
- Snapshot rule: pixel bytes always come from the snapshot. display changes during a frame never alter bytes of that frame.
- Coalescing:
  - req in a non-IDLE state sets pending.
  - req while pending is already 1 increments overrun_count, saturating at 255.
  - req on the CHECKSUM-transfer cycle is consumed directly by the recapture and does not set pending.
  - display_changed and force_refresh asserted together count as one request.
- Width rules:
  - Pixel index is $clog2(PIXEL_COUNT) bits and never wraps past PIXEL_COUNT-1.
  - Checksum is 8 bits.
- Frame length is fixed at PIXEL_COUNT+2 = 66 transfers.

Test Plan:
- Basic frame: RST, then display with pixel 9=8'h3F and pixel 14=8'h15, all others 0; pulse display_changed; hold tx_ready=1. Required: tx_valid rises one cycle later; 66 consecutive bytes FF, 00x9, 3F, 00x4, 15, 00x49, then checksum 2A; busy falls after the last transfer.
- Backpressure: same frame, tx_ready toggled 1/0 each cycle and held low for 10 cycles at pixel 20. Required: tx_data stable while stalled; byte sequence identical to the basic frame; no byte duplicated or skipped.
- Mid-frame change: start a frame; at pixel 30 change display to pixel 0=8'h30 and pulse display_changed. Required: the current frame carries the old data with checksum 2A; immediately followed by FF, 30, 00x63, checksum 30; overrun_count=0.
- Overrun: during a frame pulse display_changed 3 times (non-CHECKSUM cycles). Required: exactly one follow-up frame; overrun_count=2. Repeat 300 requests inside one frame: overrun_count saturates at FF.
- Reset mid-frame: assert RST at pixel 40 with a change pending. Required: next cycle tx_valid=0, busy=0, overrun_count=0; no follow-up frame after RST deasserts until a new request arrives.
- Simultaneous request at CHECKSUM: pulse force_refresh on the checksum-transfer cycle. Required: next cycle tx_data=FF with tx_valid held high; pending stays 0; only one extra frame is sent.

Source files
------------

// File: rtl/display_frame_streamer.sv
// Snapshots the display frame on request and streams it as SYNC, pixels, XOR checksum
// over a valid/ready byte interface. Mid-frame requests coalesce into one follow-up frame.
module display_frame_streamer #(
  parameter int unsigned PIXEL_COUNT = 64,
  parameter int unsigned PIXEL_WIDTH = 8,
  parameter logic [PIXEL_WIDTH-1:0] SYNC_BYTE = 8'hFF
) (
  input  logic                               CLK,
  input  logic                               RST,
  input  logic [PIXEL_COUNT*PIXEL_WIDTH-1:0] display,
  input  logic                               display_changed,
  input  logic                               force_refresh,
  input  logic                               tx_ready,
  output logic                               tx_valid,
  output logic [PIXEL_WIDTH-1:0]             tx_data,
  output logic                               busy,
  output logic [7:0]                         overrun_count
);

  localparam int unsigned FRAME_W = PIXEL_COUNT * PIXEL_WIDTH;
  localparam int unsigned IDX_W   = $clog2(PIXEL_COUNT);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PIXEL_COUNT - 1);
  localparam logic [7:0] OVF_MAX = 8'hFF;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HEADER,
    ST_PIXELS,
    ST_CHECKSUM
  } state_e;

  state_e                 state_q, state_d;
  logic [FRAME_W-1:0]     snap_q, snap_d;
  logic [PIXEL_WIDTH-1:0] chk_q, chk_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic                   pending_q, pending_d;
  logic [7:0]             ovf_q, ovf_d;
  logic                   tx_valid_q, tx_valid_d;
  logic [PIXEL_WIDTH-1:0] tx_data_q, tx_data_d;
  logic                   busy_q, busy_d;

  logic                   req;
  logic                   xfer;
  logic [PIXEL_WIDTH-1:0] cur_byte;
  logic [PIXEL_WIDTH-1:0] next_byte;

  assign req  = display_changed | force_refresh;
  assign xfer = tx_valid_q & tx_ready;

  // Pixel currently on the bus, and the pixel selected by the next index.
  always_comb begin
    cur_byte  = snap_q[int'(idx_q) * int'(PIXEL_WIDTH) +: PIXEL_WIDTH];
    next_byte = snap_q[int'(idx_d) * int'(PIXEL_WIDTH) +: PIXEL_WIDTH];
  end

  // State and datapath registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= ST_IDLE;
      snap_q     <= '0;
      chk_q      <= '0;
      idx_q      <= '0;
      pending_q  <= 1'b0;
      ovf_q      <= '0;
      tx_valid_q <= 1'b0;
      tx_data_q  <= '0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      snap_q     <= snap_d;
      chk_q      <= chk_d;
      idx_q      <= idx_d;
      pending_q  <= pending_d;
      ovf_q      <= ovf_d;
      tx_valid_q <= tx_valid_d;
      tx_data_q  <= tx_data_d;
      busy_q     <= busy_d;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d   = state_q;
    snap_d    = snap_q;
    chk_d     = chk_q;
    idx_d     = idx_q;
    pending_d = pending_q;
    ovf_d     = ovf_q;
    unique case (state_q)
      ST_IDLE: begin
        if (req) begin
          snap_d  = display;
          chk_d   = '0;
          idx_d   = '0;
          state_d = ST_HEADER;
        end
      end
      ST_HEADER: begin
        if (xfer) begin
          idx_d   = '0;
          state_d = ST_PIXELS;
        end
      end
      ST_PIXELS: begin
        if (xfer) begin
          chk_d = chk_q ^ cur_byte;
          if (idx_q == LAST_IDX) begin
            state_d = ST_CHECKSUM;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      ST_CHECKSUM: begin
        if (xfer) begin
          if (pending_q || req) begin
            snap_d    = display;
            chk_d     = '0;
            idx_d     = '0;
            pending_d = 1'b0;
            state_d   = ST_HEADER;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A request on the checksum-transfer cycle is absorbed by the recapture above.
    if ((state_q != ST_IDLE) && req && !((state_q == ST_CHECKSUM) && xfer)) begin
      if (pending_q) begin
        if (ovf_q != OVF_MAX) ovf_d = ovf_q + 8'd1;
      end else begin
        pending_d = 1'b1;
      end
    end
  end

  // Output decode from the upcoming state so the bus is registered.
  always_comb begin
    tx_valid_d = (state_d != ST_IDLE);
    busy_d     = (state_d != ST_IDLE);
    tx_data_d  = '0;
    unique case (state_d)
      ST_HEADER:   tx_data_d = SYNC_BYTE;
      ST_PIXELS:   tx_data_d = next_byte;
      ST_CHECKSUM: tx_data_d = chk_d;
      default:     tx_data_d = '0;
    endcase
  end

  assign tx_valid      = tx_valid_q;
  assign tx_data       = tx_data_q;
  assign busy          = busy_q;
  assign overrun_count = ovf_q;

endmodule
